argmax_layer: RTL and testbench
===============================

Name: argmax_layer

Overview:
- Terminal classifier stage; sits directly downstream of the 16-bit output-side bus width converter after ip1_layer.
- Consumes one frame of NUM_CLASSES signed 16-bit class scores on the blob stream.
- Emits the winning class index, its score and a frame-error flag as a single output beat, readable by the management SoC.

Parameters:
- DATA_W, 16, score width, two's complement.
- NUM_CLASSES, 10, scores per frame.
- IDX_W, 4, class-index width; must satisfy 2**IDX_W >= NUM_CLASSES.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- blob_din  in  DATA_W  score beat
- blob_din_en  in  1  beat valid
- blob_din_rdy  out  1  block can accept a beat
- blob_din_eop  in  1  last beat of frame; qualified by blob_din_en
- class_dout  out  IDX_W  winning class index
- class_max  out  DATA_W  winning score
- class_err  out  1  frame length differed from NUM_CLASSES
- class_dout_en  out  1  result valid
- class_dout_rdy  in  1  downstream accepts result

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Beat transfer occurs when blob_din_en && blob_din_rdy. Result transfer occurs when class_dout_en && class_dout_rdy.
- States:
  - ACCUM: blob_din_rdy = 1, class_dout_en = 0.
  - OUTPUT: blob_din_rdy = 0, class_dout_en = 1.
- blob_din_rdy and class_dout_en are decoded directly from the state register. No combinational path from input to output.
- Registers: beat counter cnt (IDX_W+1 bits), best value, best index.
- First beat of a frame (cnt == 0): load best = din, idx = 0 unconditionally.
- Later beats: update only if din > best (signed, strict). Ties keep the lowest index.
- Frame terminates on the first accepted beat with eop = 1, or on the NUM_CLASSES-th accepted beat, whichever comes first.
- On termination:
  - Move to OUTPUT next cycle; result registers reflect the final beat. Latency is 1 cycle from the last beat to class_dout_en.
  - class_err = 1 if eop arrived with cnt+1 < NUM_CLASSES, or if the NUM_CLASSES-th beat arrived without eop.
- Overlong frame: beats after an error-terminated frame start a new frame. No resynchronisation logic.
- OUTPUT holds class_dout, class_max and class_err stable until accepted. On acceptance, return to ACCUM next cycle with cnt cleared. Minimum 1 dead cycle between frames.
- Counter does not wrap: it is cleared on every termination.
- Reset values, any state including mid-frame: state = ACCUM, cnt = 0, class_dout = 0, class_max = 0, class_err = 0, class_dout_en = 0, blob_din_rdy = 1 in the cycle after the reset cycle.
- blob_din_rdy = 0 while rst is high.
- Single-beat frame (eop on first beat): result idx = 0, max = din, err = 1 when NUM_CLASSES > 1.

Optional Feature:
- Macro: ARGMAX_MARGIN_EN.
- Defined:
  - Also track the runner-up score (second register).
  - Output port class_margin (DATA_W) = best − second, computed in DATA_W+1 bits and saturated to the max positive DATA_W value.
  - Runner-up initialises to the most negative value on the first beat.
  - On update, the old best becomes second. Else if din > second, second = din.
  - On a single-beat frame, margin saturates.
- Undefined: port and registers absent; all other behaviour identical.

Decomposition:
- Shared package cnn_pkg:
  - DATA_W = 16, NUM_CLASSES = 10, IDX_W = 4.
  - State enum {ACCUM, OUTPUT}.
  - Saturation constants SMAX and SMIN.
- One sub-module: argmax_upd. Combinational compare/update of (best, idx[, second]) against (din, cnt); reused if top-k grows later.

Test Plan:
- Scores 3,−5,100,7,100,−1,0,2,9,4, eop on beat 10 -> idx = 2, max = 100, err = 0, class_dout_en 1 cycle after the 10th beat. Margin build: margin = 0.
- All ten scores −32768 -> idx = 0, max = −32768, err = 0. Margin build: margin = 0.
- eop on beat 4 (scores 1,2,9,3) -> idx = 2, max = 9, err = 1. Next frame starts clean.
- 10 beats without eop, then beat 11 -> first result err = 1. Beat 11 is counted as beat 1 of the next frame.
- Hold class_dout_rdy = 0 for 20 cycles while upstream keeps en = 1 -> blob_din_rdy = 0, outputs stable, no beats lost. Release -> ACCUM resumes 1 cycle later.
- Assert rst after beat 5 -> all outputs 0 next cycle. Then a full frame 0..9 ascending -> idx = 9, max = 9, err = 0.

Source files
------------

// File: rtl/argmax_layer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg (package)
//  Description : Shared constants and types for the argmax classifier stage.
//                DATA_W      - score width, two's complement
//                NUM_CLASSES - scores per frame
//                IDX_W       - class-index width (2**IDX_W >= NUM_CLASSES)
//                SMAX / SMIN - saturation limits of a DATA_W signed value
//                state_t     - ACCUM / OUTPUT frame states
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int DATA_W      = 16;
    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;

    localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [0:0] {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/argmax_layer_if.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_layer_if (interface)
//  Description : Score stream in, classification result out.
//                blob_din/_en/_eop/_rdy       - score beat handshake
//                class_dout/_max/_err/_en/_rdy - result handshake
//                class_margin                  - best minus runner-up
//                                                (ARGMAX_MARGIN_EN only)
//                master : upstream/downstream environment side
//                slave  : argmax_layer side
//  Options     : ARGMAX_MARGIN_EN adds class_margin
//  Revision    : 1.0 - initial release
// ============================================================================
interface argmax_layer_if;
    import cnn_pkg::*;

    logic [DATA_W-1:0] blob_din;
    logic              blob_din_en;
    logic              blob_din_rdy;
    logic              blob_din_eop;
    logic [IDX_W-1:0]  class_dout;
    logic [DATA_W-1:0] class_max;
    logic              class_err;
    logic              class_dout_en;
    logic              class_dout_rdy;
`ifdef ARGMAX_MARGIN_EN
    logic [DATA_W-1:0] class_margin;
`endif

    modport master (
        output blob_din, blob_din_en, blob_din_eop, class_dout_rdy,
`ifdef ARGMAX_MARGIN_EN
        input  class_margin,
`endif
        input  blob_din_rdy, class_dout, class_max, class_err, class_dout_en
    );

    modport slave (
        input  blob_din, blob_din_en, blob_din_eop, class_dout_rdy,
`ifdef ARGMAX_MARGIN_EN
        output class_margin,
`endif
        output blob_din_rdy, class_dout, class_max, class_err, class_dout_en
    );

endinterface
`default_nettype wire

// File: rtl/argmax_layer_upd.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_upd
//  Description : Combinational running-maximum update for one score beat.
//                first_i    - beat is the first of its frame
//                idx_cand_i - index of this beat within the frame
//                din_i      - incoming score
//                best_i/idx_i[/second_i] - current running state
//                best_o/idx_o[/second_o] - updated running state
//  Options     : ARGMAX_MARGIN_EN adds the runner-up tracking path
//  Revision    : 1.0 - initial release
// ============================================================================
module argmax_upd
    import cnn_pkg::*;
(
    input  wire logic                     first_i,
    input  wire logic [IDX_W-1:0]         idx_cand_i,
    input  wire logic signed [DATA_W-1:0] din_i,
    input  wire logic signed [DATA_W-1:0] best_i,
    input  wire logic [IDX_W-1:0]         idx_i,
`ifdef ARGMAX_MARGIN_EN
    input  wire logic signed [DATA_W-1:0] second_i,
    output logic signed [DATA_W-1:0]      second_o,
`endif
    output logic signed [DATA_W-1:0]      best_o,
    output logic [IDX_W-1:0]              idx_o
);

    always_comb begin
        best_o = best_i;
        idx_o  = idx_i;
`ifdef ARGMAX_MARGIN_EN
        second_o = second_i;
`endif
        if (first_i) begin
            best_o = din_i;
            idx_o  = '0;
`ifdef ARGMAX_MARGIN_EN
            second_o = SMIN;
`endif
        end else if (din_i > best_i) begin
            // Strict compare: an equal later score never displaces the
            // earlier one, so ties resolve to the lowest index.
            best_o = din_i;
            idx_o  = idx_cand_i;
`ifdef ARGMAX_MARGIN_EN
            second_o = best_i;
`endif
        end
`ifdef ARGMAX_MARGIN_EN
        else if (din_i > second_i) begin
            second_o = din_i;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/argmax_layer.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_layer
//  Description : Terminal classifier stage. Accumulates one frame of signed
//                class scores and presents the winning index, its score and
//                a frame-length error flag as a single held result beat.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                bus  - argmax_layer_if.slave (score stream in, result out)
//  Options     : ARGMAX_MARGIN_EN - also track the runner-up and drive
//                class_margin = best - second, saturated to SMAX
//  Revision    : 1.0 - initial release
// ============================================================================
module argmax_layer
    import cnn_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst,
    argmax_layer_if.slave bus
);

    localparam logic [IDX_W:0] c_num_classes = (IDX_W+1)'(NUM_CLASSES);

    state_t                    state_q, state_d;
    logic [IDX_W:0]            cnt_q, cnt_d;
    logic signed [DATA_W-1:0]  best_q, best_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      err_q, err_d;

    logic [IDX_W:0]            w_cnt_inc;
    logic                      w_full;
    logic signed [DATA_W-1:0]  w_upd_best;
    logic [IDX_W-1:0]          w_upd_idx;

`ifdef ARGMAX_MARGIN_EN
    logic signed [DATA_W-1:0]  second_q, second_d;
    logic signed [DATA_W-1:0]  w_upd_second;
    logic signed [DATA_W:0]    w_diff;
`endif

    assign w_cnt_inc = cnt_q + 1'b1;
    assign w_full    = (w_cnt_inc == c_num_classes);

    argmax_upd u_upd (
        .first_i    (cnt_q == '0),
        .idx_cand_i (cnt_q[IDX_W-1:0]),
        .din_i      (bus.blob_din),
        .best_i     (best_q),
        .idx_i      (idx_q),
`ifdef ARGMAX_MARGIN_EN
        .second_i   (second_q),
        .second_o   (w_upd_second),
`endif
        .best_o     (w_upd_best),
        .idx_o      (w_upd_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            best_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            second_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            best_q  <= best_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
`ifdef ARGMAX_MARGIN_EN
            second_q <= second_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        best_d  = best_q;
        idx_d   = idx_q;
        err_d   = err_q;
`ifdef ARGMAX_MARGIN_EN
        second_d = second_q;
`endif
        case (state_q)
            ACCUM: begin
                if (bus.blob_din_en) begin
                    best_d = w_upd_best;
                    idx_d  = w_upd_idx;
`ifdef ARGMAX_MARGIN_EN
                    second_d = w_upd_second;
`endif
                    if (bus.blob_din_eop || w_full) begin
                        state_d = OUTPUT;
                        cnt_d   = '0;
                        // A terminating beat is clean only when eop and the
                        // NUM_CLASSES-th beat coincide; early eop or a
                        // missing eop both flag the frame.
                        err_d   = !(bus.blob_din_eop && w_full);
                    end else begin
                        cnt_d = w_cnt_inc;
                    end
                end
            end
            OUTPUT: begin
                if (bus.class_dout_rdy) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // Ready is held low during the reset cycle itself; otherwise both
    // handshake outputs decode straight from the state register.
    assign bus.blob_din_rdy  = (state_q == ACCUM) && !rst;
    assign bus.class_dout_en = (state_q == OUTPUT);
    assign bus.class_dout    = idx_q;
    assign bus.class_max     = best_q;
    assign bus.class_err     = err_q;

`ifdef ARGMAX_MARGIN_EN
    // One extra bit keeps the subtraction exact before clamping back into
    // DATA_W.
    assign w_diff = {best_q[DATA_W-1], best_q} - {second_q[DATA_W-1], second_q};

    always_comb begin
        bus.class_margin = w_diff[DATA_W-1:0];
        if (!w_diff[DATA_W] && w_diff[DATA_W-1]) begin
            bus.class_margin = SMAX;
        end else if (w_diff[DATA_W] && !w_diff[DATA_W-1]) begin
            bus.class_margin = SMIN;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_argmax_layer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_argmax_layer
//  Description : Self-checking bench for argmax_layer. A frame-level model
//                (queue of accepted scores, argmax over the queue) predicts
//                every handshake and result field each cycle; directed
//                frames pin the model with literal expectations.
//  Options     : ARGMAX_MARGIN_EN also checks class_margin
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_argmax_layer;
    import cnn_pkg::*;

    logic clk = 1'b0;
    logic rst;

    argmax_layer_if bus();

    argmax_layer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

`ifdef ARGMAX_MARGIN_EN
    int lit_margin = -1;
`endif

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: frames are plain queues of accepted scores.
    // ------------------------------------------------------------------
    int frame[$];
    bit exp_valid  = 1'b0;
    bit just_reset = 1'b0;
    int exp_idx, exp_max, exp_err;
`ifdef ARGMAX_MARGIN_EN
    int exp_margin, runner;
`endif

    always @(negedge clk) begin
        if (rst) begin
            chk("rdy_during_rst", bus.blob_din_rdy, 0);
            frame.delete();
            exp_valid  = 1'b0;
            just_reset = 1'b1;
        end else begin
            if (just_reset) begin
                chk("rst_class_dout", bus.class_dout, 0);
                chk("rst_class_max", bus.class_max, 0);
                chk("rst_class_err", bus.class_err, 0);
                just_reset = 1'b0;
            end
            chk("class_dout_en", bus.class_dout_en, exp_valid);
            chk("blob_din_rdy", bus.blob_din_rdy, !exp_valid);
            if (exp_valid) begin
                chk("class_dout", bus.class_dout, exp_idx);
                chk("class_max", $signed(bus.class_max), exp_max);
                chk("class_err", bus.class_err, exp_err);
`ifdef ARGMAX_MARGIN_EN
                chk("class_margin", $signed(bus.class_margin), exp_margin);
`endif
            end
            // Advance the model to what the next edge commits.
            if (exp_valid) begin
                if (bus.class_dout_rdy) exp_valid = 1'b0;
            end else if (bus.blob_din_en) begin
                frame.push_back(int'($signed(bus.blob_din)));
                if (bus.blob_din_eop || frame.size() == NUM_CLASSES) begin
                    exp_idx = 0;
                    exp_max = frame[0];
                    foreach (frame[i]) begin
                        if (frame[i] > exp_max) begin
                            exp_max = frame[i];
                            exp_idx = i;
                        end
                    end
                    exp_err = (bus.blob_din_eop && frame.size() == NUM_CLASSES) ? 0 : 1;
`ifdef ARGMAX_MARGIN_EN
                    runner = -32768;
                    foreach (frame[j]) begin
                        if (j != exp_idx && frame[j] > runner) runner = frame[j];
                    end
                    exp_margin = exp_max - runner;
                    if (exp_margin > 32767) exp_margin = 32767;
`endif
                    exp_valid = 1'b1;
                    frame.delete();
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.class_dout_rdy = 1'b1;
            1:       bus.class_dout_rdy = 1'($urandom_range(0, 1));
            default: bus.class_dout_rdy = 1'b0;
        endcase
    end

    // Called at posedge+1; returns at posedge+1 after the beat transferred.
    task automatic drive_beat(input int d, input bit eop);
        int waited = 0;
        bus.blob_din     = 16'(d);
        bus.blob_din_eop = eop;
        bus.blob_din_en  = 1'b1;
        @(negedge clk);
        while (!bus.blob_din_rdy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.blob_din_rdy) chk("beat_accept_timeout", bus.blob_din_rdy, 1);
        @(posedge clk);
        #1;
        bus.blob_din_en  = 1'b0;
        bus.blob_din_eop = 1'b0;
    endtask

    task automatic send_frame(input int s[], input int eop_at);
        foreach (s[i]) drive_beat(s[i], (i == eop_at));
    endtask

    // Literal check of a result expected right after the last beat.
    task automatic wait_result(input string nm, input int idx, input int mx, input int er);
        int n = 0;
        @(negedge clk);
        while (!bus.class_dout_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, 0);
        chk({nm, "_valid"}, bus.class_dout_en, 1);
        if (bus.class_dout_en) begin
            chk({nm, "_idx"}, bus.class_dout, idx);
            chk({nm, "_max"}, $signed(bus.class_max), mx);
            chk({nm, "_err"}, bus.class_err, er);
`ifdef ARGMAX_MARGIN_EN
            if (lit_margin >= 0) chk({nm, "_margin"}, $signed(bus.class_margin), lit_margin);
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s10[];
        int s4[];
        rst                = 1'b1;
        bus.blob_din       = '0;
        bus.blob_din_en    = 1'b0;
        bus.blob_din_eop   = 1'b0;
        bus.class_dout_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_dout_en", bus.class_dout_en, 0);
        chk("reset_din_rdy", bus.blob_din_rdy, 1);
        @(posedge clk);
        #1;

        // Distinct maximum with a later tie.
        s10 = '{3, -5, 100, 7, 100, -1, 0, 2, 9, 4};
`ifdef ARGMAX_MARGIN_EN
        lit_margin = 0;
`endif
        send_frame(s10, 9);
        wait_result("t1", 2, 100, 0);

        // All scores at the negative limit.
        s10 = '{-32768, -32768, -32768, -32768, -32768,
                -32768, -32768, -32768, -32768, -32768};
        send_frame(s10, 9);
        wait_result("t2", 0, -32768, 0);
`ifdef ARGMAX_MARGIN_EN
        lit_margin = -1;
`endif

        // Short frame, then a clean one.
        s4 = '{1, 2, 9, 3};
        send_frame(s4, 3);
        wait_result("t3_short", 2, 9, 1);
        s10 = '{50, 40, 30, 20, 10, 0, -10, -20, -30, -40};
        send_frame(s10, 9);
        wait_result("t3_clean", 0, 50, 0);

        // Ten beats without eop; the eleventh starts a new frame.
        s10 = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
        send_frame(s10, -1);
        wait_result("t4_long", 9, 14, 1);
        drive_beat(-7, 1'b1);
        wait_result("t4_single", 0, -7, 1);

        // Result held back for 20 cycles while upstream keeps pushing.
        rdy_mode = 2;
        s10 = '{0, 3, 6, 9, 12, 15, 18, 21, 24, 27};
        send_frame(s10, 9);
        fork
            begin
                int s_next[];
                s_next = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
                send_frame(s_next, 9);
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    chk("hold_din_rdy", bus.blob_din_rdy, 0);
                    chk("hold_idx", bus.class_dout, 9);
                    chk("hold_max", $signed(bus.class_max), 27);
                end
                rdy_mode = 0;
            end
        join
        wait_result("t5_next", 0, 9, 0);

        // Reset in the middle of a frame.
        for (int i = 0; i < 5; i++) drive_beat(100 + i, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_dout_en", bus.class_dout_en, 0);
        chk("midrst_max", bus.class_max, 0);
        @(posedge clk);
        #1;
        s10 = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        send_frame(s10, 9);
        wait_result("t6_after_rst", 9, 9, 0);

        // Randomized traffic against the model.
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int len;
            bit use_eop;
            len     = $urandom_range(1, 13);
            use_eop = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < len; b++) begin
                logic [15:0] r;
                if ($urandom_range(0, 2) == 0) r = 16'($urandom_range(0, 4)) - 16'd2;
                else                           r = 16'($urandom);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                drive_beat(int'($signed(r)), use_eop && (b == len - 1));
            end
        end
        drive_beat(1, 1'b1);
        rdy_mode = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("drain_idle", bus.class_dout_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
